envelope_modulator: RTL and testbench
=====================================

ENVELOPE_MODULATOR -- requirements
Module: envelope_modulator

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 i_Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_Reset_n  input  1  synchronous, active-low reset.
REQ-004 i_Amplitude  input  16  signed waveform sample from the waveform generator stage.
REQ-005 i_Gate  input  1  note gate, level-sensitive; high = key held.
REQ-006 i_AttackRate  input  16  unsigned per-cycle level increment in ATTACK.
REQ-007 i_DecayRate  input  16  unsigned per-cycle level decrement in DECAY.
REQ-008 i_SustainLevel  input  16  unsigned sustain target level.
REQ-009 i_ReleaseRate  input  16  unsigned per-cycle level decrement in RELEASE.
REQ-010 o_Amplitude  output  16  signed envelope-scaled sample.
REQ-011 o_Level  output  16  unsigned current envelope level (registered).
REQ-012 o_State  output  3  encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
REQ-013 SHALL keep a 1-bit gate-history register; a rising edge is i_Gate=1 with history=0; a falling condition is i_Gate=0.
REQ-014 Priority per cycle: reset > rising edge > gate low > state-specific update.
REQ-015 On a rising edge in any state, the state SHALL become ATTACK and the level SHALL be held that cycle (retrigger does not zero the level).
REQ-016 On i_Gate=0 in ATTACK, DECAY or SUSTAIN, the state SHALL become RELEASE and the level SHALL be held that cycle.
REQ-017 IDLE: level SHALL be 0; leaves only via rising edge.
REQ-018 ATTACK: level += i_AttackRate using 17-bit sum; if sum >= 0xFFFF, level=0xFFFF and state becomes DECAY.
REQ-019 DECAY: level -= i_DecayRate using 17-bit signed difference; if difference <= i_SustainLevel (including underflow), level=i_SustainLevel and state becomes SUSTAIN.
REQ-020 SUSTAIN: level SHALL track i_SustainLevel every cycle.
REQ-021 RELEASE: level -= i_ReleaseRate; if difference <= 0, level=0 and state becomes IDLE.
REQ-022 A rate of 0 SHALL freeze the level in that state indefinitely (no transition).
REQ-023 Scaling pipeline stage 1 SHALL register i_Amplitude and the current o_Level together.
REQ-024 Stage 2 SHALL compute the signed product of the registered amplitude and {1'b0, level} (33-bit) and register bits [31:16] to o_Amplitude (arithmetic shift, floor rounding).
REQ-025 Latency i_Amplitude -> o_Amplitude SHALL be exactly 2 cycles, free-running with no stall or handshake.
REQ-026 Output SHALL never overflow: full-scale results are bounded to 0x8000..0x7FFE.

Reset
REQ-027 With i_Reset_n=0 at a clock edge, the next cycle SHALL show state IDLE, o_Level=0, o_Amplitude=0, gate history=0, and pipeline registers=0, regardless of state.
REQ-028 If i_Gate is high when reset releases, the first post-reset cycle SHALL be treated as a rising edge.

Verification
REQ-029 Scenario 1 (attack): reset, AttackRate=0x4000, gate high -> state ATTACK; level 0x0000, 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY.
REQ-030 Scenario 2 (decay): DecayRate=0x1000, SustainLevel=0xE000 from 0xFFFF -> level 0xEFFF, then 0xE000 with state SUSTAIN; change SustainLevel to 0xD000 -> level 0xD000 next cycle.
REQ-031 Scenario 3 (release): gate low in SUSTAIN at 0xE000, ReleaseRate=0x8000 -> RELEASE with level held at 0xE000, then 0x6000, then 0x0000 with state IDLE.
REQ-032 Scenario 4 (scaling), with the 2-cycle latency check:
- level 0xFFFF, amplitude 0x7FFF -> 0x7FFE;
- level 0xFFFF, amplitude 0x8000 -> 0x8000;
- level 0x8000, amplitude 0x4000 -> 0x2000;
- level 0x8000, amplitude 0xFFFF -> 0xFFFF;
- level 0 -> 0x0000.
REQ-033 Scenario 5 (retrigger): gate low mid-attack at 0x8000 -> RELEASE with 0x8000 held; gate high two cycles later -> ATTACK, level continues upward from its current value, not from 0.
REQ-034 Scenario 6 (reset mid-operation): assert i_Reset_n=0 in SUSTAIN with nonzero audio -> next cycle all outputs 0 and state IDLE; release reset with gate held high -> ATTACK next cycle.

Source files
------------

// File: rtl/envelope_modulator.sv
// ADSR envelope generator with a two-stage signed amplitude scaler.
// Envelope state and level update every cycle; audio path is a free-running 2-cycle pipe.
module envelope_modulator (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic [15:0] i_Amplitude,
   input  logic        i_Gate,
   input  logic [15:0] i_AttackRate,
   input  logic [15:0] i_DecayRate,
   input  logic [15:0] i_SustainLevel,
   input  logic [15:0] i_ReleaseRate,
   output logic [15:0] o_Amplitude,
   output logic [15:0] o_Level,
   output logic [2:0]  o_State
);

   localparam int unsigned DataW  = 16;
   localparam int unsigned ProdW  = 32;
   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [DataW-1:0]   level_q, level_d;
   logic               gate_hist_q, gate_hist_d;
   logic [DataW-1:0]   amp_s1_q, amp_s1_d;
   logic [DataW-1:0]   lvl_s1_q, lvl_s1_d;
   logic [DataW-1:0]   out_q, out_d;

   logic [DataW:0]        attack_sum_c;
   logic signed [DataW:0] decay_diff_c;
   logic signed [DataW:0] release_diff_c;
   logic signed [ProdW-1:0] prod_c;

   // Level arithmetic is one bit wider so overflow/underflow are visible.
   assign attack_sum_c   = {1'b0, level_q} + {1'b0, i_AttackRate};
   assign decay_diff_c   = $signed({1'b0, level_q}) - $signed({1'b0, i_DecayRate});
   assign release_diff_c = $signed({1'b0, level_q}) - $signed({1'b0, i_ReleaseRate});

   // Unsigned level is zero-extended so it multiplies as a non-negative gain.
   assign prod_c = $signed({{16{amp_s1_q[DataW-1]}}, amp_s1_q}) * $signed({16'd0, lvl_s1_q});

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      gate_hist_d = i_Gate;
      amp_s1_d    = i_Amplitude;
      lvl_s1_d    = level_q;
      out_d       = DataW'(prod_c >>> 16);

      if (i_Gate && !gate_hist_q) begin
         state_d = ST_ATTACK;
      end else if (!i_Gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
         state_d = ST_RELEASE;
      end else begin
         unique case (state_q)
            ST_IDLE: level_d = '0;
            ST_ATTACK: begin
               if (i_AttackRate != '0) begin
                  if (attack_sum_c >= 17'h0FFFF) begin
                     level_d = 16'hFFFF;
                     state_d = ST_DECAY;
                  end else begin
                     level_d = DataW'(attack_sum_c);
                  end
               end
            end
            ST_DECAY: begin
               if (i_DecayRate != '0) begin
                  if (decay_diff_c <= $signed({1'b0, i_SustainLevel})) begin
                     level_d = i_SustainLevel;
                     state_d = ST_SUSTAIN;
                  end else begin
                     level_d = DataW'(decay_diff_c);
                  end
               end
            end
            ST_SUSTAIN: level_d = i_SustainLevel;
            ST_RELEASE: begin
               if (i_ReleaseRate != '0) begin
                  if (release_diff_c <= 17'sd0) begin
                     level_d = '0;
                     state_d = ST_IDLE;
                  end else begin
                     level_d = DataW'(release_diff_c);
                  end
               end
            end
            default: begin
               level_d = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state_q     <= ST_IDLE;
         level_q     <= '0;
         gate_hist_q <= 1'b0;
         amp_s1_q    <= '0;
         lvl_s1_q    <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         gate_hist_q <= gate_hist_d;
         amp_s1_q    <= amp_s1_d;
         lvl_s1_q    <= lvl_s1_d;
         out_q       <= out_d;
      end
   end

   assign o_Amplitude = out_q;
   assign o_Level     = level_q;
   assign o_State     = state_q;

endmodule

// File: tb/tb_envelope_modulator.sv
// Directed bench for envelope_modulator: envelope phases, scaling, retrigger and reset.
module tb_envelope_modulator;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] amp_in;
   logic        gate;
   logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
   logic [15:0] amp_out, level;
   logic [2:0]  state;

   int vectors    = 0;
   int miscompares = 0;

   envelope_modulator dut (
      .i_Clock        (clk),
      .i_Reset_n      (reset_n),
      .i_Amplitude    (amp_in),
      .i_Gate         (gate),
      .i_AttackRate   (attack_rate),
      .i_DecayRate    (decay_rate),
      .i_SustainLevel (sustain_level),
      .i_ReleaseRate  (release_rate),
      .o_Amplitude    (amp_out),
      .o_Level        (level),
      .o_State        (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_env(input string tag, input logic [2:0] exp_st, input logic [15:0] exp_lvl);
      check({tag, ".state"}, 16'(state), 16'(exp_st));
      check({tag, ".level"}, level, exp_lvl);
   endtask

   initial begin
      reset_n = 1'b0; gate = 1'b0; amp_in = 16'h1234;
      attack_rate = 16'h0; decay_rate = 16'h0; sustain_level = 16'hE000; release_rate = 16'h0;
      tick(); tick();
      check_env("reset", 3'd0, 16'h0000);
      check("reset.amp", amp_out, 16'h0000);

      // Attack, released from reset with gate already high; decay frozen at rate 0.
      amp_in = 16'h0000; attack_rate = 16'h4000; gate = 1'b1; reset_n = 1'b1;
      tick(); check_env("atk0", 3'd1, 16'h0000);
      tick(); check_env("atk1", 3'd1, 16'h4000);
      tick(); check_env("atk2", 3'd1, 16'h8000);
      tick(); check_env("atk3", 3'd1, 16'hC000);
      tick(); check_env("atk4", 3'd2, 16'hFFFF);
      tick(); check_env("decay_frozen", 3'd2, 16'hFFFF);

      // Full-scale scaling at level 0xFFFF with 2-cycle latency.
      amp_in = 16'h7FFF;
      tick(); check("lat_not_yet", amp_out, 16'h0000);
      amp_in = 16'h8000;
      tick(); check("scale_7fff", amp_out, 16'h7FFE);
      amp_in = 16'h0000;
      tick(); check("scale_8000", amp_out, 16'h8000);

      // Decay into sustain, sustain tracking.
      decay_rate = 16'h1000;
      tick(); check_env("dec0", 3'd2, 16'hEFFF);
      tick(); check_env("dec1", 3'd3, 16'hE000);
      sustain_level = 16'hD000;
      tick(); check_env("sus_track", 3'd3, 16'hD000);
      sustain_level = 16'hE000;
      tick(); check_env("sus_back", 3'd3, 16'hE000);

      // Release to idle.
      gate = 1'b0; release_rate = 16'h8000;
      tick(); check_env("rel0", 3'd4, 16'hE000);
      tick(); check_env("rel1", 3'd4, 16'h6000);
      tick(); check_env("rel2", 3'd0, 16'h0000);
      amp_in = 16'h7FFF;
      tick(); check_env("idle_hold", 3'd0, 16'h0000);
      amp_in = 16'h0000;
      tick(); check("scale_lvl0", amp_out, 16'h0000);

      // Attack to 0x8000, then gate drop holds level in release (release frozen).
      gate = 1'b1; release_rate = 16'h0000;
      tick(); check_env("ret_atk0", 3'd1, 16'h0000);
      tick(); check_env("ret_atk1", 3'd1, 16'h4000);
      tick(); check_env("ret_atk2", 3'd1, 16'h8000);
      gate = 1'b0;
      tick(); check_env("ret_rel", 3'd4, 16'h8000);
      amp_in = 16'h4000;
      tick(); check_env("rel_frozen", 3'd4, 16'h8000);
      amp_in = 16'hFFFF;
      tick(); check("scale_half_pos", amp_out, 16'h2000);
      amp_in = 16'h0000;
      tick(); check("scale_half_neg", amp_out, 16'hFFFF);

      // Retrigger continues from the current level.
      gate = 1'b1;
      tick(); check_env("retrig", 3'd1, 16'h8000);
      tick(); check_env("retrig_up", 3'd1, 16'hC000);
      tick(); check_env("retrig_top", 3'd2, 16'hFFFF);

      // Reach sustain with audio flowing, then reset mid-operation.
      decay_rate = 16'h1000;
      tick(); check_env("r_dec0", 3'd2, 16'hEFFF);
      tick(); check_env("r_dec1", 3'd3, 16'hE000);
      amp_in = 16'h4000;
      tick(); tick(); check("scale_sus", amp_out, 16'h3800);
      reset_n = 1'b0;
      tick(); check_env("mid_reset", 3'd0, 16'h0000);
      check("mid_reset.amp", amp_out, 16'h0000);
      reset_n = 1'b1;
      tick(); check_env("post_reset", 3'd1, 16'h0000);
      tick(); check_env("post_reset_up", 3'd1, 16'h4000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
